decode_stage_pipelined: RTL

//  Registered, parametrised instruction-decode pipeline stage between fetch and execute.

---
 rtl/decode_stage_pipelined.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/decode_stage_pipelined.sv
// -----------------------------------------------------------------------------
// decode_stage_pipelined
//   Registered instruction-decode stage sitting between fetch and execute.
//   The incoming word {opcode, reg_dest, reg_src, small_imm} is decoded
//   combinationally and captured in a main register. A skid register absorbs
//   one extra word, so in_ready can be a pure register output.
//   Immediates are extended to WORD_SIZE, sign- or zero-extended per
//   SIGN_EXTEND. decode_count counts words taken downstream and saturates.
//
// Optional feature macro: DECODE_ILLEGAL_OP_EN
//   defined   : out_illegal = !LEGAL_OPCODE_MASK[opcode]; illegal words still
//               flow and count, with out_is_alu forced low.
//   undefined : out_illegal is constant 0 and LEGAL_OPCODE_MASK is ignored.
//
// Ports
//   clk, rst_n (sync, active low), flush (sync discard of buffered words)
//   in_valid / in_ready / in_instruction          : fetch-side handshake
//   out_valid / out_ready / out_*                 : execute-side handshake
//   decode_count                                  : saturating pop counter
// -----------------------------------------------------------------------------
module decode_stage_pipelined #(
  parameter int WORD_SIZE     = 16,
  parameter int OPCODE_SIZE   = 4,
  parameter int REG_ADDR_SIZE = 3,
  parameter logic [(2**OPCODE_SIZE)-1:0] ALU_OPCODE_MASK   = 16'h07FF,
  parameter int SIGN_EXTEND   = 1,
  parameter int COUNT_WIDTH   = 16,
  parameter logic [(2**OPCODE_SIZE)-1:0] LEGAL_OPCODE_MASK = 16'hFFFF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WORD_SIZE-1:0]     in_instruction,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [OPCODE_SIZE-1:0]   out_opcode,
  output logic [REG_ADDR_SIZE-1:0] out_reg_dest,
  output logic [REG_ADDR_SIZE-1:0] out_reg_src,
  output logic                     out_is_alu,
  output logic [WORD_SIZE-1:0]     out_small_imm,
  output logic [WORD_SIZE-1:0]     out_big_imm,
  output logic                     out_illegal,
  output logic [COUNT_WIDTH-1:0]   decode_count
);

  localparam int SMALL_IMM_SIZE = WORD_SIZE - OPCODE_SIZE - 2 * REG_ADDR_SIZE;
  localparam int BIG_IMM_SIZE   = REG_ADDR_SIZE + SMALL_IMM_SIZE;

  // Reject field layouts that leave no room for the small immediate, or masks
  // that do not carry exactly one bit per opcode.
  if (SMALL_IMM_SIZE < 1 ||
      $bits(ALU_OPCODE_MASK) != 2**OPCODE_SIZE ||
      $bits(LEGAL_OPCODE_MASK) != 2**OPCODE_SIZE) begin : g_bad_config
    $error("decode_stage_pipelined: inconsistent field sizes");
  end

  typedef struct packed {
    logic [OPCODE_SIZE-1:0]   opcode;
    logic [REG_ADDR_SIZE-1:0] reg_dest;
    logic [REG_ADDR_SIZE-1:0] reg_src;
    logic                     is_alu;
    logic [WORD_SIZE-1:0]     small_imm;
    logic [WORD_SIZE-1:0]     big_imm;
    logic                     illegal;
  } entry_t;

  typedef enum logic [1:0] {S_EMPTY, S_ONE, S_FULL} state_t;

  state_t                 state_q;
  entry_t                 main_q;
  entry_t                 skid_q;
  entry_t                 entry_d;
  logic                   in_ready_q;
  logic                   out_valid_q;
  logic [COUNT_WIDTH-1:0] count_q;

  logic [OPCODE_SIZE-1:0]    op_field;
  logic [SMALL_IMM_SIZE-1:0] small_field;
  logic [BIG_IMM_SIZE-1:0]   big_field;
  logic                      accept;
  logic                      pop;

  assign op_field    = in_instruction[WORD_SIZE-1 -: OPCODE_SIZE];
  assign small_field = in_instruction[SMALL_IMM_SIZE-1:0];
  assign big_field   = in_instruction[BIG_IMM_SIZE-1:0];

  assign accept = in_valid & in_ready_q;
  assign pop    = out_valid_q & out_ready;

  // Combinational decode of the offered word; it only matters on an accept.
  always_comb begin
    entry_d          = '0;
    entry_d.opcode   = op_field;
    entry_d.reg_dest = in_instruction[WORD_SIZE-OPCODE_SIZE-1 -: REG_ADDR_SIZE];
    entry_d.reg_src  = big_field[BIG_IMM_SIZE-1 -: REG_ADDR_SIZE];
    entry_d.is_alu   = ALU_OPCODE_MASK[op_field];
    if (SIGN_EXTEND != 0) begin
      entry_d.small_imm = {{(WORD_SIZE-SMALL_IMM_SIZE){small_field[SMALL_IMM_SIZE-1]}}, small_field};
      entry_d.big_imm   = {{(WORD_SIZE-BIG_IMM_SIZE){big_field[BIG_IMM_SIZE-1]}}, big_field};
    end else begin
      entry_d.small_imm = {{(WORD_SIZE-SMALL_IMM_SIZE){1'b0}}, small_field};
      entry_d.big_imm   = {{(WORD_SIZE-BIG_IMM_SIZE){1'b0}}, big_field};
    end
`ifdef DECODE_ILLEGAL_OP_EN
    entry_d.illegal = !LEGAL_OPCODE_MASK[op_field];
    if (entry_d.illegal) begin
      entry_d.is_alu = 1'b0;
    end
`endif
  end

  // Occupancy FSM. in_ready/out_valid are registered alongside the state so
  // in_ready never depends combinationally on out_ready.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_EMPTY;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      main_q      <= '0;
      skid_q      <= '0;
      count_q     <= '0;
    end else if (flush) begin
      // Flush wins over a same-cycle accept and pop; the pop is not counted.
      state_q     <= S_EMPTY;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      if (pop && (count_q != {COUNT_WIDTH{1'b1}})) begin
        count_q <= count_q + COUNT_WIDTH'(1);
      end
      case (state_q)
        S_EMPTY: begin
          if (accept) begin
            main_q      <= entry_d;
            state_q     <= S_ONE;
            out_valid_q <= 1'b1;
          end
        end
        S_ONE: begin
          if (accept && !pop) begin
            skid_q     <= entry_d;
            state_q    <= S_FULL;
            in_ready_q <= 1'b0;
          end else if (accept && pop) begin
            main_q <= entry_d;
          end else if (pop) begin
            state_q     <= S_EMPTY;
            out_valid_q <= 1'b0;
          end
        end
        S_FULL: begin
          // in_ready is low here, so only a pop can move things along.
          if (pop) begin
            main_q     <= skid_q;
            state_q    <= S_ONE;
            in_ready_q <= 1'b1;
          end
        end
        default: begin
          state_q     <= S_EMPTY;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready      = in_ready_q;
  assign out_valid     = out_valid_q;
  assign out_opcode    = main_q.opcode;
  assign out_reg_dest  = main_q.reg_dest;
  assign out_reg_src   = main_q.reg_src;
  assign out_is_alu    = main_q.is_alu;
  assign out_small_imm = main_q.small_imm;
  assign out_big_imm   = main_q.big_imm;
  // Without DECODE_ILLEGAL_OP_EN the stored flag is always 0, so this is a
  // constant 0 after optimisation.
  assign out_illegal   = main_q.illegal;
  assign decode_count  = count_q;

endmodule
